apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master.sv | 147 ++++++++++++++
 tb/tb_apb_arb_master.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_master
// Purpose  : Two-requester APB master. A round-robin arbiter picks one
//            requester per transfer. The transfer goes through
//            IDLE -> SETUP -> ACCESS -> DONE -> IDLE, and the DONE cycle
//            returns a one-cycle ack to the granted requester.
// Ports    : clk, RESETn (async, active-low)
//            req0/1, write0/1, addr0/1, wdata0/1  - requester side, held until ack
//            ack0/1, rdata, err                   - requester completion
//            PSELx, PENABLE, PWRITE, PADDR, PWDATA - APB master outputs
//            PRDATA, PREADY                        - APB slave response
// Config   : define APB_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT cycles.
//            On expiry the transfer completes with err=1 and rdata=0.
//            Without the macro, ACCESS waits forever and err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module apb_arb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic        write0,
  input  logic        write1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SETUP  = 2'd1;
  localparam logic [1:0] c_ST_ACCESS = 2'd2;
  localparam logic [1:0] c_ST_DONE   = 2'd3;

  logic [1:0] r_state;
  logic       r_last;     // requester granted by the most recent completed transfer
  logic       r_gnt;      // requester owning the transfer in flight
  logic       w_gnt;
  logic       w_timeout;  // ACCESS wait limit hit in this cycle

  // On a tie the requester that did not win last time gets the bus.
  // A lone request wins regardless of history.
  assign w_gnt = (req0 && req1) ? ~r_last : req1;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

  logic [7:0] r_wait_cnt;

  // The counter holds the number of PREADY=0 ACCESS cycles already elapsed.
  // This cycle is the last allowed wait when one more would reach TIMEOUT.
  assign w_timeout = !PREADY && ((r_wait_cnt + 8'd1) == c_TIMEOUT);

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_wait_cnt <= 8'd0;
      err        <= 1'b0;
    end else begin
      // err is a one-cycle flag aligned with the ack of a timed-out transfer
      err <= (r_state == c_ST_ACCESS) && w_timeout;
      if (r_state == c_ST_SETUP) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == c_ST_ACCESS) && !PREADY && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= c_ST_IDLE;
      r_last  <= 1'b1;      // requester 0 wins the first tie
      r_gnt   <= 1'b0;
      PSELx   <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 32'd0;
      PWDATA  <= 32'd0;
      rdata   <= 32'd0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (req0 || req1) begin
            r_gnt   <= w_gnt;
            PWRITE  <= w_gnt ? write1 : write0;
            PADDR   <= w_gnt ? addr1  : addr0;
            PWDATA  <= w_gnt ? wdata1 : wdata0;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= c_ST_SETUP;
          end
        end
        c_ST_SETUP: begin
          PENABLE <= 1'b1;
          r_state <= c_ST_ACCESS;
        end
        c_ST_ACCESS: begin
          if (PREADY || w_timeout) begin
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            ack0    <= ~r_gnt;
            ack1    <= r_gnt;
            r_state <= c_ST_DONE;
            if (w_timeout) begin
              rdata <= 32'd0;
            end else if (!PWRITE) begin
              rdata <= PRDATA;
            end
          end
        end
        c_ST_DONE: begin
          // No arbitration here: a requester that drops req on seeing ack
          // must not be sampled again for this transfer.
          r_last  <= r_gnt;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arb_master
// Purpose  : Self-checking bench for apb_arb_master. A reactive slave process
//            answers APB accesses after a programmable number of wait cycles.
//            Transaction-level expectations (grant order, cycle of each phase,
//            returned data) come from the arbitration and timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_arb_master;

  logic        clk = 1'b0;
  logic        RESETn;
  logic        req0, req1, write0, write1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [31:0] rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY;

  int tests_run    = 0;
  int tests_failed = 0;

  // slave behaviour knobs
  int          slave_wait  = 0;
  logic [31:0] slave_data  = 32'd0;
  bit          slave_never = 1'b0;
  int          acc_cnt     = 0;

  always #5 clk = ~clk;

  apb_arb_master #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .RESETn  (RESETn),
    .req0    (req0),
    .req1    (req1),
    .write0  (write0),
    .write1  (write1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack0    (ack0),
    .ack1    (ack1),
    .rdata   (rdata),
    .err     (err),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  // Reactive slave: PREADY=1 on ACCESS cycle number slave_wait (0-based).
  initial begin
    PREADY = 1'b0;
    PRDATA = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      PRDATA = slave_data;
      if (PSELx && PENABLE) begin
        PREADY  = !slave_never && (acc_cnt >= slave_wait);
        acc_cnt = acc_cnt + 1;
      end else begin
        PREADY  = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    step();
    step();
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    step();
    tests_run++;
    if ({PSELx, PENABLE, PWRITE, ack0, ack1, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000", {PSELx, PENABLE, PWRITE, ack0, ack1, err});
    end
    tests_run++;
    if (PADDR !== 32'd0 || PWDATA !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_apb_bus: got PADDR=%h PWDATA=%h expected 0", PADDR, PWDATA);
    end
    tests_run++;
    if (rdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    RESETn = 1'b1;
    step();
    tests_run++;
    if ({PSELx, PENABLE, ack0, ack1} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b expected 0000", {PSELx, PENABLE, ack0, ack1});
    end
  endtask

  task automatic test_write0();
    logic [4:0] exp;
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
    slave_wait = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = {(c == 1 || c == 2), (c == 2), (c == 3), 1'b0, 1'b0};
      tests_run++;
      if ({PSELx, PENABLE, ack0, ack1, err} !== exp) begin
        tests_failed++;
        $display("FAIL write0_cycle%0d: got psel/pen/ack0/ack1/err=%b expected %b", c, {PSELx, PENABLE, ack0, ack1, err}, exp);
      end
      if (c <= 2) begin
        tests_run++;
        if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'd5, 32'hDEADBEEF}) begin
          tests_failed++;
          $display("FAIL write0_bus_cycle%0d: got %b/%h/%h expected 1/00000005/deadbeef", c, PWRITE, PADDR, PWDATA);
        end
      end
      if (c == 3) begin
        tests_run++;
        if (rdata !== 32'd0) begin
          tests_failed++;
          $display("FAIL write0_rdata_kept: got %h expected 0", rdata);
        end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_read1_wait();
    logic [4:0] exp;
    req1 = 1'b1; write1 = 1'b0; addr1 = 32'd5; wdata1 = 32'h0;
    slave_wait = 3; slave_data = 32'hDEADBEEF;
    for (int c = 1; c <= 7; c++) begin
      step();
      exp = {(c >= 1 && c <= 5), (c >= 2 && c <= 5), 1'b0, (c == 6), 1'b0};
      tests_run++;
      if ({PSELx, PENABLE, ack0, ack1, err} !== exp) begin
        tests_failed++;
        $display("FAIL read1_cycle%0d: got psel/pen/ack0/ack1/err=%b expected %b", c, {PSELx, PENABLE, ack0, ack1, err}, exp);
      end
      if (c <= 5) begin
        tests_run++;
        if ({PWRITE, PADDR} !== {1'b0, 32'd5}) begin
          tests_failed++;
          $display("FAIL read1_bus_cycle%0d: got %b/%h expected 0/00000005", c, PWRITE, PADDR);
        end
      end
      if (c == 6) begin
        tests_run++;
        if (rdata !== 32'hDEADBEEF) begin
          tests_failed++;
          $display("FAIL read1_rdata: got %h expected deadbeef", rdata);
        end
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    bit          held    [2];
    bit          m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    int          last, g, waits;
    bit          in_done;
    logic [1:0]  pick;
    logic [4:0]  exp;
    logic [31:0] data, exp_rdata;
    do_reset();
    last = 1; exp_rdata = 32'd0; in_done = 1'b0;
    for (int r = 0; r < 2; r++) begin
      held[r] = 1'b0; m_wr[r] = 1'b0; m_addr[r] = 32'd0; m_wdata[r] = 32'd0;
    end
    for (int n = 0; n < 24; n++) begin
      pick = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (pick[r] && !held[r]) begin
          held[r] = 1'b1; m_wr[r] = 1'($urandom_range(0, 1));
          m_addr[r] = $urandom; m_wdata[r] = $urandom;
        end
      end
      req0 = held[0]; write0 = m_wr[0]; addr0 = m_addr[0]; wdata0 = m_wdata[0];
      req1 = held[1]; write1 = m_wr[1]; addr1 = m_addr[1]; wdata1 = m_wdata[1];
      if (in_done) begin
        step();
        tests_run++;
        if ({PSELx, PENABLE, ack0, ack1} !== 4'b0) begin
          tests_failed++;
          $display("FAIL rand%0d_idle: got %b expected 0000", n, {PSELx, PENABLE, ack0, ack1});
        end
      end
      // round robin: on a tie the one not served last wins
      if (held[0] && held[1]) g = (last == 0) ? 1 : 0;
      else                    g = held[1] ? 1 : 0;
      waits = $urandom_range(0, 3);
      data  = $urandom;
      slave_wait = waits; slave_data = data;
      for (int k = 1; k <= 3 + waits; k++) begin
        step();
        exp = {(k <= 2 + waits), (k >= 2 && k <= 2 + waits),
               (k == 3 + waits && g == 0), (k == 3 + waits && g == 1), 1'b0};
        tests_run++;
        if ({PSELx, PENABLE, ack0, ack1, err} !== exp) begin
          tests_failed++;
          $display("FAIL rand%0d_cycle%0d: got psel/pen/ack0/ack1/err=%b expected %b (grant %0d)", n, k, {PSELx, PENABLE, ack0, ack1, err}, exp, g);
        end
        if (k <= 2 + waits) begin
          tests_run++;
          if ({PWRITE, PADDR, PWDATA} !== {m_wr[g], m_addr[g], m_wdata[g]}) begin
            tests_failed++;
            $display("FAIL rand%0d_bus%0d: got %b/%h/%h expected %b/%h/%h", n, k, PWRITE, PADDR, PWDATA, m_wr[g], m_addr[g], m_wdata[g]);
          end
        end
      end
      if (!m_wr[g]) exp_rdata = data;
      tests_run++;
      if (rdata !== exp_rdata) begin
        tests_failed++;
        $display("FAIL rand%0d_rdata: got %h expected %h", n, rdata, exp_rdata);
      end
      held[g] = 1'b0;
      last    = g;
      in_done = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ack;
    int n;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; write0 = 1'b0; write1 = 1'b0;
    addr0 = 32'h10; addr1 = 32'h20;
    slave_wait = 0; slave_data = 32'h12345678;
    for (int c = 1; c <= 16; c++) begin
      step();
      n = c / 4;
      exp_ack = (c % 4 == 3) ? ((n % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      tests_run++;
      if ({ack0, ack1} !== exp_ack) begin
        tests_failed++;
        $display("FAIL b2b_ack_cycle%0d: got ack0/ack1=%b expected %b", c, {ack0, ack1}, exp_ack);
      end
      if (c % 4 == 1) begin
        tests_run++;
        if (PADDR !== ((n % 2 == 1) ? 32'h20 : 32'h10)) begin
          tests_failed++;
          $display("FAIL b2b_paddr_cycle%0d: got %h expected %h", c, PADDR, (n % 2 == 1) ? 32'h20 : 32'h10);
        end
      end
      if (c % 4 == 3) begin
        tests_run++;
        if (rdata !== 32'h12345678) begin
          tests_failed++;
          $display("FAIL b2b_rdata_cycle%0d: got %h expected 12345678", c, rdata);
        end
      end
      if (c == 16) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp;
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h40; wdata0 = 32'hA5A5A5A5;
    slave_never = 1'b1;
    step(); step(); step();
    tests_run++;
    if ({PSELx, PENABLE} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rstmid_in_access: got psel/pen=%b expected 11", {PSELx, PENABLE});
    end
    #2;
    RESETn = 1'b0;
    req0   = 1'b0;
    #1;
    tests_run++;
    if ({PSELx, PENABLE, PWRITE, ack0, ack1, err, PADDR, PWDATA, rdata} !== 102'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got ctrl=%b PADDR=%h PWDATA=%h rdata=%h expected all 0", {PSELx, PENABLE, PWRITE, ack0, ack1, err}, PADDR, PWDATA, rdata);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if ({PSELx, ack0, ack1} !== 3'b0) begin
        tests_failed++;
        $display("FAIL rstmid_held%0d: got psel/ack0/ack1=%b expected 000", c, {PSELx, ack0, ack1});
      end
    end
    RESETn = 1'b1; slave_never = 1'b0; slave_wait = 0;
    req0 = 1'b1; write0 = 1'b1; addr0 = 32'h44; wdata0 = $urandom;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = {(c == 1 || c == 2), (c == 2), (c == 3), 1'b0, 1'b0};
      tests_run++;
      if ({PSELx, PENABLE, ack0, ack1, err} !== exp) begin
        tests_failed++;
        $display("FAIL rstmid_after_cycle%0d: got %b expected %b", c, {PSELx, PENABLE, ack0, ack1, err}, exp);
      end
      if (c == 3) req0 = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic [4:0] exp;
    req0 = 1'b1; write0 = 1'b0; addr0 = 32'h80;
    slave_never = 1'b1; slave_data = 32'hCAFEF00D;
`ifdef APB_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      step();
      exp = {(c <= 5), (c >= 2 && c <= 5), (c == 6), 1'b0, (c == 6)};
      tests_run++;
      if ({PSELx, PENABLE, ack0, ack1, err} !== exp) begin
        tests_failed++;
        $display("FAIL timeout_cycle%0d: got psel/pen/ack0/ack1/err=%b expected %b", c, {PSELx, PENABLE, ack0, ack1, err}, exp);
      end
      if (c == 6) begin
        tests_run++;
        if (rdata !== 32'd0) begin
          tests_failed++;
          $display("FAIL timeout_rdata: got %h expected 0", rdata);
        end
        req0 = 1'b0;
      end
    end
`else
    for (int c = 1; c <= 120; c++) begin
      step();
      if (c >= 2) begin
        tests_run++;
        if ({PSELx, PENABLE, ack0, ack1, err} !== 5'b11000) begin
          tests_failed++;
          $display("FAIL nowait_limit_cycle%0d: got psel/pen/ack0/ack1/err=%b expected 11000", c, {PSELx, PENABLE, ack0, ack1, err});
        end
      end
    end
    req0 = 1'b0;
`endif
    slave_never = 1'b0;
    do_reset();
  endtask

  initial begin
    RESETn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    test_reset();
    test_write0();
    test_read1_wait();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
